// File: rtl/prog_mem.sv
// prog_mem: program memory with a byte-stream loader and a falling-edge fetch port.
// The loader runs on the rising clk edge; the CPU fetch register updates on the falling edge.
// Optional: define PROG_MEM_CHECKSUM_EN to add a CHECK state that validates one trailing
// checksum byte against an 8-bit running sum of the image bytes.
module prog_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   input  logic                  ld_start,
   input  logic [7:0]            ld_byte,
   input  logic                  ld_valid,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  busy,
   output logic                  ld_done,
   output logic                  ld_err,
   output logic [ADDR_WIDTH:0]   ld_words
);

   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int CNT_W  = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
`ifdef PROG_MEM_CHECKSUM_EN
      S_CHECK = 2'd2,
`endif
      S_DONE  = 2'd3
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [BIDX_W-1:0]     bidx_q, bidx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0]      words_q, words_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] data_q;
`ifdef PROG_MEM_CHECKSUM_EN
   logic [7:0]            sum_q, sum_d;
`endif

   logic                  accept;
   logic                  word_end;
   logic                  mem_full;
   logic                  we;
   logic [DATA_WIDTH-1:0] wr_word;

`ifdef PROG_MEM_CHECKSUM_EN
   assign busy = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
   assign busy = (state_q == S_LOAD);
`endif
   assign ld_ready = busy;
   assign ld_done  = (state_q == S_DONE);
   assign ld_err   = err_q;
   assign ld_words = words_q;
   assign data     = data_q;

   assign accept   = ld_valid && ld_ready;
   // A word closes on its top byte, or early when the image ends mid-word.
   assign word_end = (bidx_q == BIDX_W'(BYTES - 1)) || ld_last;
   // Once DEPTH words are written the pointer has wrapped; further bytes overflow.
   assign mem_full = words_q[ADDR_WIDTH];

   // Merge the incoming byte into the little-endian word buffer; unfilled bytes stay zero.
   always_comb begin
      wr_word = word_q;
      for (int b = 0; b < BYTES; b++) begin
         if (bidx_q == BIDX_W'(b)) wr_word[8*b +: 8] = ld_byte;
      end
   end

   // Loader next-state logic and write strobe.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      bidx_d  = bidx_q;
      word_d  = word_q;
      words_d = words_q;
      err_d   = err_q;
      we      = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ld_start) begin
               state_d = S_LOAD;
               wptr_d  = '0;
               bidx_d  = '0;
               word_d  = '0;
               words_d = '0;
               err_d   = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (mem_full) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
`ifdef PROG_MEM_CHECKSUM_EN
                  sum_d = sum_q + ld_byte;
`endif
                  if (word_end) begin
                     we      = 1'b1;
                     wptr_d  = wptr_q + ADDR_WIDTH'(1);
                     words_d = words_q + CNT_W'(1);
                     bidx_d  = '0;
                     word_d  = '0;
                  end else begin
                     bidx_d  = bidx_q + BIDX_W'(1);
                     word_d  = wr_word;
                  end
                  if (ld_last) begin
`ifdef PROG_MEM_CHECKSUM_EN
                     state_d = S_CHECK;
`else
                     state_d = S_DONE;
`endif
                  end
               end
            end
         end
`ifdef PROG_MEM_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (8'(sum_q + ld_byte) != 8'h00) err_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Loader state registers; async reset drops any partial word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         bidx_q  <= '0;
         word_q  <= '0;
         words_q <= '0;
         err_q   <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         words_q <= words_d;
         err_q   <= err_d;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) mem[wptr_q] <= wr_word;
   end

   // Fetch register on the falling edge; NOP (all zeros) while a load is in progress.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= busy ? '0 : mem[addr];
   end

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem (DATA_WIDTH=16, ADDR_WIDTH=2 so overflow is reachable).
module tb_prog_mem;
   localparam int DW = 16;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data;
   logic          ld_start = 1'b0;
   logic [7:0]    ld_byte = '0;
   logic          ld_valid = 1'b0;
   logic          ld_last = 1'b0;
   logic          ld_ready, busy, ld_done, ld_err;
   logic [AW:0]   ld_words;

   always #5 clk = ~clk;

   prog_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
      .ld_start(ld_start), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_last(ld_last),
      .ld_ready(ld_ready), .busy(busy), .ld_done(ld_done), .ld_err(ld_err),
      .ld_words(ld_words)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]    img [16];
   logic          rd_req = 1'b0;
   logic [DW-1:0] rd_exp [$];
   string         rd_nm [$];
   logic [AW+1:0] done_exp [$];   // {err, words}
   logic [AW+1:0] de;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: compares fetched words and load-completion status against queued expectations.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rd_req) begin
            if (rd_exp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL fetch: data %h with no expectation queued", data);
            end else begin
               chk(rd_nm.pop_front(), data, rd_exp.pop_front());
            end
         end
         if (ld_done) begin
            if (done_exp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL ld_done: unexpected pulse, got 1 expected 0 (t=%0t)", $time);
            end else begin
               de = done_exp.pop_front();
               chk("done_err", ld_err, de[AW+1]);
               chk("done_words", ld_words, de[AW:0]);
               chk("done_busy", busy, 0);
               chk("done_ready", ld_ready, 0);
            end
         end
      end
   end

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string nm);
      addr   = a;
      rd_req = 1'b1;
      rd_exp.push_back(e);
      rd_nm.push_back(nm);
      @(posedge clk); #1 rd_req = 1'b0;
   endtask

   // Starts a load and presents n bytes of img, one per cycle; ld_start is re-pulsed
   // on the third byte, which must be ignored outside IDLE.
   task automatic do_load(input int n, input int last_at);
      @(posedge clk); #1 ld_start = 1'b1;
      @(posedge clk); #1 ld_start = 1'b0;
      chk("busy_in_load", busy, 1);
      chk("ready_in_load", ld_ready, 1);
      addr   = '0;
      rd_req = 1'b1;
      rd_exp.push_back('0);
      rd_nm.push_back("nop_while_busy");
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_byte  = img[i];
         ld_last  = (i == last_at);
         ld_start = (i == 2);
         @(posedge clk); #1 rd_req = 1'b0;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_start = 1'b0;
      ld_byte  = '0;
   endtask

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_data", data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_done", ld_done, 0);
      chk("rst_err", ld_err, 0);
      chk("rst_words", ld_words, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Two full little-endian words
      img[0] = 8'h01; img[1] = 8'hE0; img[2] = 8'h31; img[3] = 8'hB9;
      done_exp.push_back({1'b0, 3'd2});
      do_load(4, 3);
      rd(2'd0, 16'hE001, "t1_mem0");
      rd(2'd1, 16'hB931, "t1_mem1");

      // Odd-length image: last word zero-filled
      img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
      done_exp.push_back({1'b0, 3'd2});
      do_load(3, 2);
      rd(2'd0, 16'hBBAA, "t2_mem0");
      rd(2'd1, 16'h00CC, "t2_mem1");

      // Overflow: 10 bytes into a 4-word memory, no ld_last
      for (int i = 0; i < 10; i++) img[i] = 8'h10 + 8'(i);
      done_exp.push_back({1'b1, 3'd4});
      do_load(10, -1);
      chk("ovf_err_held", ld_err, 1);
      chk("ovf_words_held", ld_words, 4);
      rd(2'd0, 16'h1110, "ovf_mem0_untouched");
      rd(2'd3, 16'h1716, "ovf_mem3");

      // Checksum trailer (consumed only when the checksum option is built in)
      img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'hFD;
      done_exp.push_back({1'b0, 3'd1});
      do_load(3, 1);
      rd(2'd0, 16'h0201, "ck_mem0");
      img[2] = 8'hFE;
`ifdef PROG_MEM_CHECKSUM_EN
      done_exp.push_back({1'b1, 3'd1});
`else
      done_exp.push_back({1'b0, 3'd1});
`endif
      do_load(3, 1);

      // Reset in the middle of a load
      img[0] = 8'h55; img[1] = 8'h66; img[2] = 8'h77;
      do_load(3, -1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data", data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", ld_ready, 0);
      chk("mid_rst_err", ld_err, 0);
      chk("mid_rst_words", ld_words, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_done", ld_done, 0);
      chk("mid_rst_data_hold", data, 0);
      rst_n = 1'b1;
      rd(2'd0, 16'h6655, "rst_mem0_kept");
      rd(2'd1, 16'h1312, "rst_partial_lost");

      repeat (3) @(posedge clk);
      #1;
      chk("done_queue_drained", done_exp.size(), 0);
      chk("fetch_queue_drained", rd_exp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width; legal values are multiples of 8 from 8 to 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk, input, 1, the single clock; rising edge drives the loader, falling edge drives the read port.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port addr, input, ADDR_WIDTH, CPU fetch address (program counter).
REQ-006 SHALL have port data, output, DATA_WIDTH, registered instruction word.
REQ-007 SHALL have port ld_start, input, 1, one-cycle pulse that begins a program load.
REQ-008 SHALL have port ld_byte, input, 8, loader data byte.
REQ-009 SHALL have port ld_valid, input, 1, ld_byte is valid this cycle.
REQ-010 SHALL have port ld_last, input, 1, the accepted byte is the final image byte.
REQ-011 SHALL have port ld_ready, output, 1, a byte is accepted when ld_valid and ld_ready are both 1 at a rising edge.
REQ-012 SHALL have port busy, output, 1, a load is in progress.
REQ-013 SHALL have port ld_done, output, 1, one-cycle pulse marking the end of a load.
REQ-014 SHALL have port ld_err, output, 1, load-failed flag; held from ld_done until the next ld_start.
REQ-015 SHALL have port ld_words, output, ADDR_WIDTH+1, count of words written by the last load.

Function
REQ-016 SHALL update data at each falling clk edge: mem[addr] when busy=0, all zeros (NOP) when busy=1.
REQ-017 SHALL implement loader states IDLE, LOAD, CHECK and DONE, all advancing on the rising clk edge.
REQ-018 SHALL move IDLE->LOAD on ld_start; on entry it clears the write pointer, byte index, ld_words, ld_err and the checksum.
REQ-019 SHALL ignore ld_start in every state other than IDLE.
REQ-020 SHALL drive ld_ready=1 only in LOAD and CHECK; bytes presented in IDLE or DONE are dropped.
REQ-021 SHALL assemble bytes little-endian, first byte into bits [7:0], and write mem[wptr] in the same edge that accepts the word's final byte, then increment wptr and ld_words.
REQ-022 SHALL, when ld_last is accepted mid-word, zero-fill the upper bytes and write that partial word.
REQ-023 SHALL leave LOAD on ld_last, going to CHECK when PROG_MEM_CHECKSUM_EN is defined and to DONE otherwise.
REQ-024 SHALL treat any accepted byte arriving after word DEPTH-1 has been written (wptr wrapped) as overflow.
REQ-025 SHALL, on overflow, discard the byte, leave memory unwritten, set ld_err, and go to DONE.
REQ-026 SHALL hold DONE for exactly one cycle, with ld_done=1 and busy=0, then return to IDLE.
REQ-027 SHALL drive busy=1 in LOAD and CHECK only.
REQ-028 SHALL see a fetch issued on the falling edge after a write at the same address return the new word.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE and data=0, with busy, ld_ready, ld_done, ld_err and ld_words all 0.
REQ-030 SHALL NOT have memory contents affected by reset.
REQ-031 SHALL, when reset asserts mid-load, retain words already written, lose the partial word, and raise no ld_done.

Configuration
REQ-032 SHALL, with PROG_MEM_CHECKSUM_EN defined, keep an 8-bit running sum of image bytes.
REQ-033 SHALL, in CHECK, accept one checksum byte; ld_err=1 if (sum + byte) mod 256 != 0; then go to DONE.
REQ-034 SHALL, without PROG_MEM_CHECKSUM_EN, omit the CHECK state and the sum logic; ld_err then reflects overflow only.

Verification
REQ-035 SHALL cover: load bytes 01,E0,31,B9 with last on 4th -> mem[0]=E001, mem[1]=B931, ld_words=2, ld_done pulse, ld_err=0.
REQ-036 SHALL cover: load 3 bytes AA,BB,CC with last on 3rd -> mem[1]=00CC, ld_words=2.
REQ-037 SHALL cover: during a load with addr=0 -> data=0000 and busy=1; after DONE -> data=mem[0].
REQ-038 SHALL cover: ADDR_WIDTH=2, 10 bytes loaded -> ld_err=1 after the 9th byte, ld_words=4, mem[0] untouched by the extra byte.
REQ-039 SHALL cover: with the macro, image 01,02 + checksum FD -> ld_err=0; checksum FE -> ld_err=1.
REQ-040 SHALL cover: rst_n low after 3 bytes -> state IDLE, mem[0] retained, no ld_done, data=0.
